mc_main_control: RTL and testbench

- Multicycle MIPS main control FSM; generates the 2-bit ALU_Op consumed by the ALU control decoder, plus all datapath enables and mux selects.
- Sits between the instruction register opcode field and the multicycle datapath (PC, memory, IR, register file, ALU muxes).
- Moore machine: all control outputs decode from the state register only.

---
 rtl/mc_main_control.sv | 196 +++++++++++++++++++
 tb/tb_mc_main_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS main control FSM (Moore decode of the
// state register). Produces datapath enables, mux selects and the 2-bit
// ALU_Op for the ALU control decoder.
// Optional feature macro: MC_ADDI_EN (adds addi via ADDIEX/ADDIWB states).
module mc_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALU_Op,
    output logic [1:0]         PCSource,
    output logic               Illegal_Op,
    output logic               Instr_Done,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   illegal_s;
    logic   pc_write_s;
    logic   pc_write_cond_s;
    logic   mem_write_s;
    logic   ir_write_s;
    logic   reg_write_s;
    logic   instr_done_s;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; Opcode only matters in DECODE and MEMADR.
    always_comb begin
        next_state_s = FETCH;
        illegal_s    = 1'b0;
        case (state_r)
            FETCH:  next_state_s = DECODE;
            DECODE: begin
                case (Opcode)
                    6'h00:        next_state_s = EXEC;
                    6'h23, 6'h2B: next_state_s = MEMADR;
                    6'h04:        next_state_s = BRANCH;
                    6'h02:        next_state_s = JUMP;
`ifdef MC_ADDI_EN
                    6'h08:        next_state_s = ADDIEX;
`endif
                    default: begin
                        next_state_s = FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            // IR is only written in FETCH, so Opcode[3] still tells sw from lw.
            MEMADR: begin
                if (Opcode[3]) begin
                    next_state_s = MEMWR;
                end else begin
                    next_state_s = MEMRD;
                end
            end
            MEMRD:  next_state_s = MEMWB;
            MEMWB:  next_state_s = FETCH;
            MEMWR:  next_state_s = FETCH;
            EXEC:   next_state_s = ALUWB;
            ALUWB:  next_state_s = FETCH;
            BRANCH: next_state_s = FETCH;
            JUMP:   next_state_s = FETCH;
`ifdef MC_ADDI_EN
            ADDIEX: next_state_s = ADDIWB;
            ADDIWB: next_state_s = FETCH;
`endif
            default: next_state_s = FETCH;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        IorD            = 1'b0;
        MemRead         = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        MemtoReg        = 1'b0;
        RegDst          = 1'b0;
        reg_write_s     = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        ALU_Op          = 2'b00;
        PCSource        = 2'b00;
        instr_done_s    = 1'b0;
        case (state_r)
            FETCH: begin
                MemRead    = 1'b1;
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcB    = 2'b01;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                reg_write_s  = 1'b1;
                MemtoReg     = 1'b1;
                instr_done_s = 1'b1;
            end
            MEMWR: begin
                mem_write_s  = 1'b1;
                IorD         = 1'b1;
                instr_done_s = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALU_Op  = 2'b10;
            end
            ALUWB: begin
                reg_write_s  = 1'b1;
                RegDst       = 1'b1;
                instr_done_s = 1'b1;
            end
            BRANCH: begin
                ALUSrcA         = 1'b1;
                ALU_Op          = 2'b01;
                pc_write_cond_s = 1'b1;
                PCSource        = 2'b01;
                instr_done_s    = 1'b1;
            end
            JUMP: begin
                pc_write_s   = 1'b1;
                PCSource     = 2'b10;
                instr_done_s = 1'b1;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
`endif
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Architectural side effects are suppressed while reset is held.
    assign PCWrite     = pc_write_s      & ~reset;
    assign PCWriteCond = pc_write_cond_s & ~reset;
    assign MemWrite    = mem_write_s     & ~reset;
    assign IRWrite     = ir_write_s      & ~reset;
    assign RegWrite    = reg_write_s     & ~reset;
    assign Illegal_Op  = illegal_s       & ~reset;
    assign Instr_Done  = instr_done_s    & ~reset;
    assign State       = STATE_W'(state_r);

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: the stimulus process pushes the
// hand-derived expected output vector for each cycle; a monitor pops and
// compares on the falling edge.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal_Op, Instr_Done;
    logic [1:0] ALUSrcB, ALU_Op, PCSource;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    logic [21:0] exp_q[$];
    string       name_q[$];
    logic [21:0] act_vec;
    bit          stim_done = 1'b0;

    mc_main_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op),
        .PCSource(PCSource), .Illegal_Op(Illegal_Op),
        .Instr_Done(Instr_Done), .State(State)
    );

    always #5 clk = ~clk;

    assign act_vec = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                      IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                      ALUSrcB, ALU_Op, PCSource, Illegal_Op, Instr_Done};

    // Expected outputs for a state, straight from the per-state output table.
    function automatic logic [21:0] expv(input logic [3:0] st, input logic rst,
                                         input logic ill);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, il, dn;
        logic [1:0] sb, op, ps;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, il, dn} = 12'd0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mr = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
            4'd5:  begin mw = 1'b1; iord = 1'b1; dn = 1'b1; end
            4'd6:  begin sa = 1'b1; op = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
            4'd8:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; dn = 1'b1; end
            4'd9:  begin pw = 1'b1; ps = 2'b10; dn = 1'b1; end
            4'd10: begin sa = 1'b1; sb = 2'b10; end
            4'd11: begin rw = 1'b1; dn = 1'b1; end
            default: ;
        endcase
        il = ill;
        if (rst) begin
            {pw, pwc, mw, rw, irw, il, dn} = 7'd0;
        end
        return {st, pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, il, dn};
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic cyc(input string nm, input logic rst, input logic [5:0] op,
                       input logic [3:0] st, input logic ill);
        reset  = rst;
        Opcode = op;
        exp_q.push_back(expv(st, rst, ill));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the scoreboard each falling edge.
    initial begin
        logic [21:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                total++;
                if (act_vec !== e) begin
                    bad++;
                    $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                             n, act_vec[21:18], act_vec, e[21:18], e);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        Opcode = 6'h00;
        @(posedge clk);
        #1;
        cyc("reset_hold1", 1'b1, 6'h00, 4'd0, 1'b0);
        cyc("reset_hold2", 1'b1, 6'h00, 4'd0, 1'b0);
        // lw
        cyc("lw_fetch",  1'b0, 6'h23, 4'd0, 1'b0);
        cyc("lw_decode", 1'b0, 6'h23, 4'd1, 1'b0);
        cyc("lw_memadr", 1'b0, 6'h23, 4'd2, 1'b0);
        cyc("lw_memrd",  1'b0, 6'h23, 4'd3, 1'b0);
        cyc("lw_memwb",  1'b0, 6'h23, 4'd4, 1'b0);
        // R-type, sw, beq back-to-back
        cyc("r_fetch",   1'b0, 6'h00, 4'd0, 1'b0);
        cyc("r_decode",  1'b0, 6'h00, 4'd1, 1'b0);
        cyc("r_exec",    1'b0, 6'h00, 4'd6, 1'b0);
        cyc("r_aluwb",   1'b0, 6'h00, 4'd7, 1'b0);
        cyc("sw_fetch",  1'b0, 6'h2B, 4'd0, 1'b0);
        cyc("sw_decode", 1'b0, 6'h2B, 4'd1, 1'b0);
        cyc("sw_memadr", 1'b0, 6'h2B, 4'd2, 1'b0);
        cyc("sw_memwr",  1'b0, 6'h2B, 4'd5, 1'b0);
        cyc("beq_fetch", 1'b0, 6'h04, 4'd0, 1'b0);
        cyc("beq_decode",1'b0, 6'h04, 4'd1, 1'b0);
        cyc("beq_branch",1'b0, 6'h04, 4'd8, 1'b0);
        // jump and illegal
        cyc("j_fetch",   1'b0, 6'h02, 4'd0, 1'b0);
        cyc("j_decode",  1'b0, 6'h02, 4'd1, 1'b0);
        cyc("j_jump",    1'b0, 6'h02, 4'd9, 1'b0);
        cyc("ill_fetch", 1'b0, 6'h3F, 4'd0, 1'b0);
        cyc("ill_decode",1'b0, 6'h3F, 4'd1, 1'b1);
        // addi
        cyc("addi_fetch",  1'b0, 6'h08, 4'd0, 1'b0);
`ifdef MC_ADDI_EN
        cyc("addi_decode", 1'b0, 6'h08, 4'd1, 1'b0);
        cyc("addi_ex",     1'b0, 6'h08, 4'd10, 1'b0);
        cyc("addi_wb",     1'b0, 6'h08, 4'd11, 1'b0);
`else
        cyc("addi_illegal",1'b0, 6'h08, 4'd1, 1'b1);
`endif
        // reset in the middle of lw, while in MEMRD
        cyc("rst_fetch",  1'b0, 6'h23, 4'd0, 1'b0);
        cyc("rst_decode", 1'b0, 6'h23, 4'd1, 1'b0);
        cyc("rst_memadr", 1'b0, 6'h23, 4'd2, 1'b0);
        cyc("rst_memrd",  1'b1, 6'h23, 4'd3, 1'b0);
        cyc("rst_after",  1'b0, 6'h23, 4'd0, 1'b0);
        cyc("rst_decode2",1'b0, 6'h00, 4'd1, 1'b0);
        stim_done = 1'b1;
    end

    // End of run: let the monitor drain, then report.
    initial begin
        wait (stim_done);
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
